// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore-FSM control unit for a multicycle MIPS-subset datapath.
//               Optional memory wait handshake: MULTICYCLE_CONTROL_MEM_WAIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zf,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IMMEX  = 4'd10,
        IMMWB  = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_illegal;
    logic [15:0] r_instr_count;
    logic        w_mem_done;
    logic        w_illegal_op;
    logic        w_retire;

    // zf qualifies the branch in the datapath, not here.
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    assign w_mem_done = mem_ready;
    logic w_unused;
    assign w_unused = zf;
`else
    assign w_mem_done = 1'b1;
    logic w_unused;
    assign w_unused = &{1'b0, zf, mem_ready};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_illegal     <= 1'b0;
            r_instr_count <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if (w_illegal_op)
                r_illegal <= 1'b1;
            if (w_retire)
                r_instr_count <= r_instr_count + 16'h0001;
        end
    end

    always_comb begin
        w_next_state = FETCH;
        w_illegal_op = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            FETCH:  w_next_state = w_mem_done ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    c_OP_RTYPE:       w_next_state = EXEC;
                    c_OP_LW, c_OP_SW: w_next_state = MEMADR;
                    c_OP_BEQ:         w_next_state = BRANCH;
                    c_OP_J:           w_next_state = JUMP;
                    c_OP_ADDI:        w_next_state = IMMEX;
                    default: begin
                        w_next_state = FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                // An opcode that changed under us mid-instruction just abandons it.
                if (opcode == c_OP_LW)
                    w_next_state = MEMRD;
                else if (opcode == c_OP_SW)
                    w_next_state = MEMWR;
                else
                    w_next_state = FETCH;
            end
            MEMRD:  w_next_state = w_mem_done ? MEMWB : MEMRD;
            MEMWB:  begin w_next_state = FETCH; w_retire = 1'b1; end
            MEMWR:  begin
                w_next_state = w_mem_done ? FETCH : MEMWR;
                w_retire     = w_mem_done;
            end
            EXEC:   w_next_state = RWB;
            RWB:    begin w_next_state = FETCH; w_retire = 1'b1; end
            BRANCH: begin w_next_state = FETCH; w_retire = 1'b1; end
            JUMP:   begin w_next_state = FETCH; w_retire = 1'b1; end
            IMMEX:  w_next_state = IMMWB;
            IMMWB:  begin w_next_state = FETCH; w_retire = 1'b1; end
            default: w_next_state = FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        case (r_state)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            IMMWB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign state       = r_state;
    assign illegal     = r_illegal;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed, table-driven self-checking bench for multicycle_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zf;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [1:0]  pc_source;
    logic [3:0]  state;
    logic        illegal;
    logic [15:0] instr_count;

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zf            (zf),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .illegal       (illegal),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    logic [16:0] ctrl_act;
    assign ctrl_act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    int checks = 0;
    int errors = 0;

    function automatic logic [16:0] ctrl_exp(input logic [3:0] s);
        logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa;
        logic [1:0] asb, psrc;
        logic [2:0] aop;
        {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa} = 10'b0;
        asb = 2'b00; aop = 3'b000; psrc = 2'b00;
        case (s)
            4'd0:  begin pw = 1; mr = 1; irw = 1; asb = 2'b01; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin asa = 1; aop = 3'b010; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin asa = 1; aop = 3'b001; pwc = 1; psrc = 2'b01; end
            4'd9:  begin pw = 1; psrc = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]      opcode;
        logic            zf;
        int              len;
        logic [4:0][3:0] seq;
        int              inc;
        logic            ill;
    } vec_t;

    function automatic logic [4:0][3:0] mk(input logic [3:0] s0, s1, s2, s3, s4);
        return {s4, s3, s2, s1, s0};
    endfunction

    vec_t vecs [10];
    int   exp_cnt;
    logic exp_ill;

    initial begin
        vecs[0] = '{6'b100011, 1'b1, 5, mk(0, 1, 2, 3, 4), 1, 1'b0}; // lw
        vecs[1] = '{6'b101011, 1'b0, 4, mk(0, 1, 2, 5, 0), 1, 1'b0}; // sw
        vecs[2] = '{6'b000000, 1'b0, 4, mk(0, 1, 6, 7, 0), 1, 1'b0}; // R-type
        vecs[3] = '{6'b001000, 1'b0, 4, mk(0, 1, 10, 11, 0), 1, 1'b0}; // addi
        vecs[4] = '{6'b000100, 1'b1, 3, mk(0, 1, 8, 0, 0), 1, 1'b0}; // beq taken
        vecs[5] = '{6'b000100, 1'b0, 3, mk(0, 1, 8, 0, 0), 1, 1'b0}; // beq not taken
        vecs[6] = '{6'b000010, 1'b0, 3, mk(0, 1, 9, 0, 0), 1, 1'b0}; // j
        vecs[7] = '{6'b111111, 1'b0, 2, mk(0, 1, 0, 0, 0), 0, 1'b1}; // illegal
        vecs[8] = '{6'b000001, 1'b0, 2, mk(0, 1, 0, 0, 0), 0, 1'b1}; // illegal again
        vecs[9] = '{6'b000010, 1'b0, 3, mk(0, 1, 9, 0, 0), 1, 1'b0}; // j after illegal

        rst = 1'b1; opcode = 6'b0; zf = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_ctrl", 32'(ctrl_act), 32'(ctrl_exp(4'd0)));

        exp_cnt = 0;
        exp_ill = 1'b0;
        for (int i = 0; i < 10; i++) begin
            opcode = vecs[i].opcode;
            zf     = vecs[i].zf;
            for (int k = 0; k < vecs[i].len; k++) begin
                chk($sformatf("v%0d_state%0d", i, k), 32'(state), 32'(vecs[i].seq[k]));
                chk($sformatf("v%0d_ctrl%0d", i, k), 32'(ctrl_act), 32'(ctrl_exp(vecs[i].seq[k])));
                @(negedge clk);
            end
            exp_cnt = exp_cnt + vecs[i].inc;
            exp_ill = exp_ill | vecs[i].ill;
            chk($sformatf("v%0d_end_state", i), 32'(state), 32'd0);
            chk($sformatf("v%0d_count", i), 32'(instr_count), 32'(exp_cnt));
            chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(exp_ill));
        end

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
        // FETCH and MEMWR stall while mem_ready is low.
        opcode = 6'b101011; mem_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            chk("fetch_hold_state", 32'(state), 32'd0);
            chk("fetch_hold_pcw", 32'(pc_write), 32'd1);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        chk("fetch_release", 32'(state), 32'd0);
        @(negedge clk);
        chk("wait_decode", 32'(state), 32'd1);
        @(negedge clk);
        chk("wait_memadr", 32'(state), 32'd2);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("memwr_hold_state", 32'(state), 32'd5);
            chk("memwr_hold_write", 32'(mem_write), 32'd1);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        chk("memwr_last_state", 32'(state), 32'd5);
        chk("memwr_last_write", 32'(mem_write), 32'd1);
        @(negedge clk);
        exp_cnt++;
        chk("memwr_exit", 32'(state), 32'd0);
        chk("memwr_count", 32'(instr_count), 32'(exp_cnt));
`else
        // mem_ready is ignored: lw runs at full speed with it held low.
        opcode = 6'b100011; mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("nowait_state%0d", k), 32'(state), 32'(k));
            @(negedge clk);
        end
        exp_cnt++;
        chk("nowait_exit", 32'(state), 32'd0);
        chk("nowait_count", 32'(instr_count), 32'(exp_cnt));
        mem_ready = 1'b1;
`endif

        // Counter wrap: reset, 65535 jumps to 0xFFFF, one more wraps to 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_clears_illegal", 32'(illegal), 32'd0);
        chk("rst_clears_count", 32'(instr_count), 32'd0);
        opcode = 6'b000010; mem_ready = 1'b1;
        repeat (3 * 65535) @(negedge clk);
        chk("count_ffff", 32'(instr_count), 32'h0000FFFF);
        chk("count_ffff_state", 32'(state), 32'd0);
        repeat (3) @(negedge clk);
        chk("count_wrap", 32'(instr_count), 32'd0);
        repeat (3) @(negedge clk);
        chk("count_after_wrap", 32'(instr_count), 32'd1);

        // Reset in EXEC returns straight to FETCH.
        opcode = 6'b000000;
        repeat (2) @(negedge clk);
        chk("exec_before_rst", 32'(state), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_exec_state", 32'(state), 32'd0);
        chk("rst_exec_count", 32'(instr_count), 32'd0);
        chk("rst_exec_ctrl", 32'(ctrl_act), 32'(ctrl_exp(4'd0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
